// File: rtl/sbox.sv
// AES forward S-box cell: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = '0;
        xx = x;
        for (int n = 0; n < 8; n++) begin
            if (y[n]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned s);
        return (b << s) | (b >> (8 - s));
    endfunction

    logic [7:0] x2_c, x3_c, x6_c, x7_c, x14_c, x15_c, x30_c, x31_c;
    logic [7:0] x62_c, x63_c, x126_c, x127_c, inv_c;

    // a^254 is the field inverse (and maps 0 to 0)
    always_comb begin
        x2_c   = gmul(a, a);
        x3_c   = gmul(x2_c, a);
        x6_c   = gmul(x3_c, x3_c);
        x7_c   = gmul(x6_c, a);
        x14_c  = gmul(x7_c, x7_c);
        x15_c  = gmul(x14_c, a);
        x30_c  = gmul(x15_c, x15_c);
        x31_c  = gmul(x30_c, a);
        x62_c  = gmul(x31_c, x31_c);
        x63_c  = gmul(x62_c, a);
        x126_c = gmul(x63_c, x63_c);
        x127_c = gmul(x126_c, a);
        inv_c  = gmul(x127_c, x127_c);
    end

    assign c = inv_c ^ rotl(inv_c, 1) ^ rotl(inv_c, 2) ^ rotl(inv_c, 3) ^ rotl(inv_c, 4) ^ 8'h63;

endmodule

// File: rtl/key_schedule_gen.sv
// Iterative AES-128/192/256 key schedule: one expanded word per cycle, full schedule
// kept in a word store and served as registered 128-bit round keys, forward or reversed.
module key_schedule_gen #(
    parameter int unsigned MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    input  logic [1:0]              key_len,
    input  logic                    load,
    output logic                    ready,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              nr,
    input  logic                    rev,
    input  logic [3:0]              rk_idx,
    output logic [127:0]            rk_out
);

    localparam int unsigned NK_MAX = MAX_KEY_BITS / 32;
    localparam int unsigned NR_MAX = NK_MAX + 6;
    localparam int unsigned WORDS  = 4 * (NR_MAX + 1);
    localparam int unsigned WIN    = 8;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] store [WORDS];
    logic [31:0] win [WIN];
    logic [5:0]  i_q;
    logic [2:0]  phase;
    logic [3:0]  nk;
    logic [7:0]  rcon;

    logic [31:0] kw_c [WIN];
    logic        len_ok_c;
    logic [3:0]  nk_sel_c;
    logic [3:0]  nr_sel_c;
    logic        accept_c;
    logic        reject_c;
    logic        step_c;
    logic        last_c;
    logic [31:0] prev_c;
    logic [31:0] old_c;
    logic [31:0] sub_in_c;
    logic [31:0] sub_out_c;
    logic [31:0] temp_c;
    logic [31:0] new_c;
    logic [3:0]  j_c;
    logic        rd_ok_c;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key words w0.. taken from the MSBs; slots beyond the widest key read as zero
    for (genvar m = 0; m < WIN; m++) begin : g_kw
        if (m < NK_MAX) begin : g_w
            assign kw_c[m] = key_in[MAX_KEY_BITS-1-32*m -: 32];
        end else begin : g_z
            assign kw_c[m] = '0;
        end
    end

    always_comb begin
        nk_sel_c = 4'd4;
        nr_sel_c = 4'd10;
        len_ok_c = 1'b1;
        case (key_len)
            2'b00: ;
            2'b01: begin
                nk_sel_c = 4'd6;
                nr_sel_c = 4'd12;
                len_ok_c = (MAX_KEY_BITS >= 192);
            end
            2'b10: begin
                nk_sel_c = 4'd8;
                nr_sel_c = 4'd14;
                len_ok_c = (MAX_KEY_BITS >= 256);
            end
            default: len_ok_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        reject_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (i_q == {nr, 2'b11});
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    if (len_ok_c) begin
                        accept_c = 1'b1;
                        state_n  = EXPAND;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            EXPAND: begin
                step_c = 1'b1;
                if (last_c) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Window slot 0 holds w[i-1]; slot Nk-1 holds w[i-Nk]
    always_comb begin
        prev_c   = win[0];
        old_c    = win[3'(nk - 4'd1)];
        sub_in_c = (phase == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
        if (phase == 3'd0)
            temp_c = sub_out_c ^ {rcon, 24'h0};
        else if (nk == 4'd8 && phase == 3'd4)
            temp_c = sub_out_c;
        else
            temp_c = prev_c;
        new_c = old_c ^ temp_c;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .a(sub_in_c[8*b +: 8]),
            .c(sub_out_c[8*b +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= '0;
            phase <= '0;
            nk    <= '0;
            rcon  <= '0;
            nr    <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            for (int unsigned k = 0; k < WIN; k++) win[k] <= '0;
        end else begin
            ready <= (state_n != EXPAND);
            done  <= (state_n == DONE);
            err   <= reject_c;
            if (accept_c) begin
                nk    <= nk_sel_c;
                nr    <= nr_sel_c;
                i_q   <= 6'(nk_sel_c);
                phase <= '0;
                rcon  <= 8'h01;
                for (int unsigned k = 0; k < WIN; k++)
                    win[k] <= (4'(k) < nk_sel_c) ? kw_c[3'(nk_sel_c - 4'(k) - 4'd1)] : '0;
            end else if (step_c) begin
                i_q   <= i_q + 6'd1;
                phase <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0) rcon <= xtime(rcon);
                win[0] <= new_c;
                for (int unsigned k = 1; k < WIN; k++) win[k] <= win[k-1];
            end
        end
    end

    // Word store is not reset; done gates its visibility
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int unsigned k = 0; k < NK_MAX; k++)
                if (4'(k) < nk_sel_c) store[k] <= kw_c[k];
        end else if (step_c) begin
            store[i_q] <= new_c;
        end
    end

    // j > nr happens exactly when rk_idx > nr, in either order
    always_comb begin
        j_c     = rev ? (nr - rk_idx) : rk_idx;
        rd_ok_c = done && !accept_c && (rk_idx <= nr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rk_out <= '0;
        else if (rd_ok_c)
            rk_out <= {store[{j_c, 2'b00}], store[{j_c, 2'b01}],
                       store[{j_c, 2'b10}], store[{j_c, 2'b11}]};
        else
            rk_out <= '0;
    end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen using FIPS-197 expansion vectors.
module tb_key_schedule_gen;

    localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_0123456789abcdef_fedcba9876543210;
    localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_a5a5a5a5c3c3c3c3;
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam int NV = 20;

    typedef struct {
        logic [1:0]   klen;
        logic         rev;
        logic [3:0]   idx;
        logic [127:0] rk;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic [1:0]   key_len;
    logic         load;
    logic         ready;
    logic         done;
    logic         err;
    logic [3:0]   nr;
    logic         rev;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    int errors = 0;
    int checks = 0;
    logic [127:0] sb_q[$];
    vec_t vt [NV];

    key_schedule_gen #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_len(key_len), .load(load),
        .ready(ready), .done(done), .err(err), .nr(nr),
        .rev(rev), .rk_idx(rk_idx), .rk_out(rk_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [127:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got output with empty scoreboard expected an entry", name);
        end else begin
            exp = sb_q.pop_front();
            check(name, rk_out, exp);
        end
    endtask

    task automatic start_load(input logic [1:0] kl, input logic [255:0] k);
        key_len = kl;
        key_in  = k;
        load    = 1'b1;
        rev     = 1'b0;
        rk_idx  = 4'd1;
        sb_q.push_back('0);
        @(posedge clk); #1;
        load = 1'b0;
        sb_check("rd_at_load");
        check("ready_after_accept", 128'(ready), 128'(0));
        check("done_after_accept", 128'(done), 128'(0));
    endtask

    task automatic load_key(input logic [1:0] kl, input logic [255:0] k, input int exp_n,
                            input logic [3:0] exp_nr, input bit poke);
        int  n;
        bit  ready_bad;
        bit  err_seen;
        n = 0;
        ready_bad = 0;
        err_seen = 0;
        start_load(kl, k);
        while (!done && n < 200) begin
            if (poke && n == 10) begin
                load    = 1'b1;
                key_len = 2'b10;
                key_in  = KEY256;
            end
            @(posedge clk); #1;
            load = 1'b0;
            n++;
            if (!done && ready) ready_bad = 1;
            if (err) err_seen = 1;
        end
        check($sformatf("cycles_to_done k%0d", kl), 128'(n), 128'(exp_n));
        check("ready_low_while_expanding", 128'(ready_bad), 128'(0));
        check("ready_at_done", 128'(ready), 128'(1));
        check("nr", 128'(nr), 128'(exp_nr));
        if (poke) check("no_err_on_ignored_load", 128'(err_seen), 128'(0));
    endtask

    task automatic run_rows(input logic [1:0] kl);
        for (int v = 0; v < NV; v++) begin
            if (vt[v].klen == kl) begin
                rev    = vt[v].rev;
                rk_idx = vt[v].idx;
                sb_q.push_back(vt[v].rk);
                @(posedge clk); #1;
                sb_check($sformatf("rk k%0d rev%0d idx%0d", kl, vt[v].rev, vt[v].idx));
            end
        end
    endtask

    initial begin
        vt[0]  = '{2'd0, 1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vt[1]  = '{2'd0, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vt[2]  = '{2'd0, 1'b0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vt[3]  = '{2'd0, 1'b0, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vt[4]  = '{2'd0, 1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[5]  = '{2'd0, 1'b1, 4'd0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[6]  = '{2'd0, 1'b1, 4'd1,  128'hac7766f319fadc2128d12941575c006e};
        vt[7]  = '{2'd0, 1'b0, 4'd11, 128'h0};
        vt[8]  = '{2'd0, 1'b1, 4'd11, 128'h0};
        vt[9]  = '{2'd1, 1'b0, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vt[10] = '{2'd1, 1'b0, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vt[11] = '{2'd1, 1'b0, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vt[12] = '{2'd1, 1'b1, 4'd12, 128'h8e73b0f7da0e6452c810f32b809079e5};
        vt[13] = '{2'd1, 1'b0, 4'd13, 128'h0};
        vt[14] = '{2'd2, 1'b1, 4'd0,  128'hfe4890d1e6188d0b046df344706c631e};
        vt[15] = '{2'd2, 1'b1, 4'd14, 128'h603deb1015ca71be2b73aef0857d7781};
        vt[16] = '{2'd2, 1'b1, 4'd13, 128'h1f352c073b6108d72d9810a30914dff4};
        vt[17] = '{2'd2, 1'b0, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vt[18] = '{2'd2, 1'b0, 4'd15, 128'h0};
        vt[19] = '{2'd2, 1'b1, 4'd15, 128'h0};

        rst_n = 1'b0; load = 1'b0; key_in = '0; key_len = 2'b00; rev = 1'b0; rk_idx = 4'd0;
        #12;
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_done", 128'(done), 128'(0));
        check("reset_err", 128'(err), 128'(0));
        check("reset_nr", 128'(nr), 128'(0));
        check("reset_rk_out", rk_out, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // AES-128 with an ignored load in the middle of expansion
        load_key(2'd0, KEY128, 40, 4'd10, 1'b1);
        run_rows(2'd0);

        // Reserved length in DONE: one-cycle err, schedule untouched
        key_len = 2'b11; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("err_pulse", 128'(err), 128'(1));
        check("err_ready", 128'(ready), 128'(1));
        check("err_done_held", 128'(done), 128'(1));
        @(posedge clk); #1;
        check("err_cleared", 128'(err), 128'(0));
        rev = 1'b0; rk_idx = 4'd1;
        sb_q.push_back(128'ha0fafe1788542cb123a339392a6c7605);
        @(posedge clk); #1;
        sb_check("rk_after_err");

        load_key(2'd1, KEY192, 46, 4'd12, 1'b0);
        run_rows(2'd1);
        load_key(2'd2, KEY256, 52, 4'd14, 1'b0);
        run_rows(2'd2);

        // Reload in DONE with a shorter key
        load_key(2'd0, KEY128, 40, 4'd10, 1'b0);
        run_rows(2'd0);

        // Reset in the middle of AES-256 expansion
        start_load(2'd2, KEY256);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_ready", 128'(ready), 128'(1));
        check("midrst_nr", 128'(nr), 128'(0));
        check("midrst_rk_out", rk_out, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load_key(2'd0, KEY128, 40, 4'd10, 1'b0);
        run_rows(2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_schedule_gen.md
# key_schedule_gen

Iterative, multi-length AES key schedule engine supporting AES-128/192/256 selected per key load. It generates one 32-bit schedule word per cycle through a single four-lane S-box datapath and stores the complete schedule. It then serves any 128-bit round key on a registered read port, in forward order for encryption or reversed order for decryption. It sits between the key register and the round datapath of both the cipher and inverse-cipher cores, replacing per-round combinational expansion.

## Interface
- MAX_KEY_BITS, 256: widest supported key; legal values 128, 192, 256; sizes key_in and word store (4*(Nr_max+1) words).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_in  in  MAX_KEY_BITS  cipher key, w0 at MSBs; key occupies key_in[MAX_KEY_BITS-1 -: key length], lower bits ignored.
- key_len  in  2  00=128 (Nk=4,Nr=10), 01=192 (Nk=6,Nr=12), 10=256 (Nk=8,Nr=14), 11 reserved; sampled with load.
- load  in  1  start request; accepted only when ready=1.
- ready  out  1  engine accepts load.
- done  out  1  complete schedule valid; level, held until next accepted load.
- err  out  1  one-cycle pulse: load with key_len=11, or with a length exceeding MAX_KEY_BITS; load is then ignored.
- nr  out  4  round count of latched schedule (10/12/14).
- rev  in  1  0: round index j=rk_idx; 1: j=nr-rk_idx (decryption order).
- rk_idx  in  4  requested round key index.
- rk_out  out  128  round key j = {w[4j],w[4j+1],w[4j+2],w[4j+3]}.

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset → IDLE.
- IDLE/DONE with load=1 and legal key_len:
  - Write w[0..Nk-1] into the word store and into an 8-word sliding window.
  - Set i=Nk, rcon=0x01, and latch nr.
  - Clear done and go to EXPAND.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If i mod Nk==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80→0x1b→0x36).
  - Else if Nk==8 and i mod 8==4: temp = SubWord(w[i-1]).
  - w[i] = w[i-Nk] ^ temp.
  - Write w[i], shift the window, and increment i.
  - w[i-1] and w[i-Nk] come from the window only; there are no random word-store reads during expansion.
- SubWord uses four instances of the existing sbox cell (ports a, c).
- The last word is i=4*Nr+3 (43/51/59). Writing it moves the FSM to DONE, setting done=1 and ready=1.
- load in EXPAND is ignored (ready=0) with no err.
- load in DONE restarts expansion; the old schedule is invalid from the accept edge.
- Read port: if j>nr or done=0, rk_out is registered as 0; otherwise rk_out is registered from the store. rev and rk_idx are sampled every cycle.
- Reset clears state, i, rcon, and all outputs. The word store is not reset; done gates its visibility.

## Timing
- Reset values: ready=1, done=0, err=0, nr=0, rk_out=0.
- Load accepted at edge T. EXPAND runs 4*Nr+4-Nk cycles: 40/46/52.
- done=1 and ready=1 from edge T+40/46/52. ready=0 for edges T..T+N-1.
- err asserts at edge T+1-cycle-equivalent of the rejected load, i.e. for exactly the cycle after the sampling edge.
- Read latency: 1 cycle (rk_idx/rev at edge E → rk_out valid after E).
- Back-to-back reads: one per cycle, no bubbles.
- Reset asserted mid-EXPAND: immediate return to IDLE with done=0. A fresh load is required.
- Simultaneous load and read in DONE: the read at that edge returns 0, because done drops.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c → done 40 cycles after load. rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles, nr=12. rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 cycles. rev=1, rk_idx=0 gives fe4890d1e6188d0b046df344706c631e; rev=1, rk_idx=14 gives 603deb1015ca71be2b73aef0857d7781.
- key_len=11 with load → err pulses for one cycle, ready stays 1, done unchanged. rk_idx=15 in DONE → rk_out=0. load pulsed during EXPAND → ignored.
- rst_n low at cycle 20 of AES-256 expansion → done=0 and rk_out=0 immediately. Reloading the AES-128 key then reproduces the first scenario's values.
- Reload in DONE with a different length (256→128) → done low for 40 cycles, then nr=10 and the AES-128 round keys are correct.
